// File: rtl/fsm1s_rle_encoder.sv
// Run-length encoder for a 1-bit FSM output stream: closes runs into (level, length)
// records and queues them in a small FIFO behind a valid/ready handshake.
module fsm1s_rle_encoder #(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  input  logic                          flush,
  output logic                          rle_valid,
  input  logic                          rle_ready,
  output logic                          rle_level,
  output logic [LEN_W-1:0]              rle_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [LEN_W-1:0] MaxLen = '1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state, w_state_d;
  logic             r_cur_level, w_cur_level_d;
  logic [LEN_W-1:0] r_cur_len, w_cur_len_d;

  logic             w_emit;
  logic             w_emit_level;
  logic [LEN_W-1:0] w_emit_len;

  logic             r_mem_level [FIFO_DEPTH];
  logic [LEN_W-1:0] r_mem_len   [FIFO_DEPTH];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr, w_rd_next;
  logic [CntW-1:0]  r_count, w_count_d;
  logic             r_overflow;
  logic             r_head_level, w_head_level_d;
  logic [LEN_W-1:0] r_head_len, w_head_len_d;
  logic             w_full, w_pop, w_push;

  // Accumulator: flush wins over a same-cycle bit, which is then dropped.
  always_comb begin
    w_state_d     = r_state;
    w_cur_level_d = r_cur_level;
    w_cur_len_d   = r_cur_len;
    w_emit        = 1'b0;
    w_emit_level  = r_cur_level;
    w_emit_len    = r_cur_len;
    unique case (r_state)
      StIdle: begin
        if (!flush && bit_valid) begin
          w_cur_level_d = bit_in;
          w_cur_len_d   = LEN_W'(1);
          w_state_d     = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          w_emit    = 1'b1;
          w_state_d = StIdle;
        end else if (bit_valid) begin
          if (bit_in == r_cur_level && r_cur_len != MaxLen) begin
            w_cur_len_d = r_cur_len + LEN_W'(1);
          end else begin
            // Level change or saturated run: close it and start a fresh length-1 run.
            w_emit        = 1'b1;
            w_cur_level_d = bit_in;
            w_cur_len_d   = LEN_W'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cur_level <= 1'b0;
      r_cur_len   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cur_level <= w_cur_level_d;
      r_cur_len   <= w_cur_len_d;
    end
  end

  assign w_full    = (r_count == CntW'(FIFO_DEPTH));
  assign w_pop     = (r_count != '0) && rle_ready;
  assign w_push    = w_emit && (!w_full || w_pop);
  assign w_rd_next = r_rd_ptr + PtrW'(1);

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  // Head registers track the slot that will be at the front after this edge.
  always_comb begin
    w_head_level_d = r_head_level;
    w_head_len_d   = r_head_len;
    if (w_pop) begin
      if (r_count > CntW'(1)) begin
        w_head_level_d = r_mem_level[w_rd_next];
        w_head_len_d   = r_mem_len[w_rd_next];
      end else if (w_push) begin
        w_head_level_d = w_emit_level;
        w_head_len_d   = w_emit_len;
      end
    end else if (r_count == '0 && w_push) begin
      w_head_level_d = w_emit_level;
      w_head_len_d   = w_emit_len;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_level[i] <= 1'b0;
        r_mem_len[i]   <= '0;
      end
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_head_level <= 1'b0;
      r_head_len   <= '0;
    end else begin
      if (w_push) begin
        r_mem_level[r_wr_ptr] <= w_emit_level;
        r_mem_len[r_wr_ptr]   <= w_emit_len;
        r_wr_ptr              <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_emit && !w_push) begin
        r_overflow <= 1'b1;
      end
      r_count      <= w_count_d;
      r_head_level <= w_head_level_d;
      r_head_len   <= w_head_len_d;
    end
  end

  assign rle_valid  = (r_count != '0);
  assign rle_level  = r_head_level;
  assign rle_len    = r_head_len;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign busy       = (r_state == StRun) || (r_count != '0);

endmodule
